// File: rtl/debounce_pkg.sv
// rtl/debounce_pkg.sv - shared state encoding and 100 MHz board defaults for the multi-channel debouncer.
package debounce_pkg;

    typedef enum logic [1:0] {
        ST_IDLE_LO = 2'd0,
        ST_CHK_HI  = 2'd1,
        ST_IDLE_HI = 2'd2,
        ST_CHK_LO  = 2'd3
    } state_e;

    // 10 ms stability window, 500 ms first repeat, 100 ms repeat period at 100 MHz
    localparam int DEF_N_CH          = 5;
    localparam int DEF_LIMIT         = 1000000;
    localparam int DEF_SYNC_STAGES   = 2;
    localparam int DEF_REPEAT_DELAY  = 50000000;
    localparam int DEF_REPEAT_PERIOD = 10000000;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/debounce_chan.sv
// rtl/debounce_chan.sv - one debounce channel: synchroniser, stability FSM, press/release pulses.
// Optional auto-repeat of press while held high is enabled by DEBOUNCE_AUTOREPEAT_EN.
module debounce_chan
    import debounce_pkg::*;
#(
    parameter int LIMIT         = DEF_LIMIT,
    parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
    input  logic clk,
    input  logic rst,
    input  logic i_noise,
    output logic o_calm,
    output logic o_press,
    output logic o_release
);

    localparam int CW = $clog2(LIMIT + 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(LIMIT - 1);

    if (LIMIT < 1 || SYNC_STAGES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_param
        $error("debounce_chan: parameter below minimum");
    end

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_s;
    state_e                 r_state;
    state_e                 w_state_nxt;
    logic [CW-1:0]          r_cnt;
    logic [CW-1:0]          w_cnt_nxt;
    logic                   r_calm;
    logic                   w_calm_nxt;
    logic                   r_press;
    logic                   w_press_nxt;
    logic                   r_release;
    logic                   w_release_nxt;
    logic                   w_rep_fire;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_noise};
        end
    end

    assign w_s = r_sync[SYNC_STAGES-1];

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_calm_nxt    = r_calm;
        w_press_nxt   = 1'b0;
        w_release_nxt = 1'b0;
        case (r_state)
            ST_IDLE_LO: begin
                // LIMIT=1 accepts on the first differing cycle, skipping the check state
                if (w_s) begin
                    if (LIMIT == 1) begin
                        w_state_nxt = ST_IDLE_HI;
                        w_calm_nxt  = 1'b1;
                        w_press_nxt = 1'b1;
                    end else begin
                        w_state_nxt = ST_CHK_HI;
                        w_cnt_nxt   = CNT_ONE;
                    end
                end
            end
            ST_CHK_HI: begin
                if (!w_s) begin
                    w_state_nxt = ST_IDLE_LO;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = ST_IDLE_HI;
                    w_cnt_nxt   = '0;
                    w_calm_nxt  = 1'b1;
                    w_press_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
            ST_IDLE_HI: begin
                if (!w_s) begin
                    if (LIMIT == 1) begin
                        w_state_nxt   = ST_IDLE_LO;
                        w_calm_nxt    = 1'b0;
                        w_release_nxt = 1'b1;
                    end else begin
                        w_state_nxt = ST_CHK_LO;
                        w_cnt_nxt   = CNT_ONE;
                    end
                end
            end
            ST_CHK_LO: begin
                if (w_s) begin
                    w_state_nxt = ST_IDLE_HI;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt   = ST_IDLE_LO;
                    w_cnt_nxt     = '0;
                    w_calm_nxt    = 1'b0;
                    w_release_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE_LO;
                w_cnt_nxt   = '0;
            end
        endcase
    end

`ifdef DEBOUNCE_AUTOREPEAT_EN
    localparam int RW = $clog2(max2(REPEAT_DELAY, REPEAT_PERIOD) + 1);
    localparam logic [RW-1:0] REP_ONE        = RW'(1);
    localparam logic [RW-1:0] REP_DELAY_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] REP_PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

    logic [RW-1:0] r_rep_cnt;
    logic          r_rep_arm;
    logic          w_rep_hold;

    // r_rep_arm selects the period once the first (longer) delay has elapsed
    assign w_rep_hold = (r_state == ST_IDLE_HI) && w_s;
    assign w_rep_fire = w_rep_hold &&
                        (r_rep_cnt == (r_rep_arm ? REP_PERIOD_LAST : REP_DELAY_LAST));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rep_cnt <= '0;
            r_rep_arm <= 1'b0;
        end else if (!w_rep_hold) begin
            r_rep_cnt <= '0;
            r_rep_arm <= 1'b0;
        end else if (w_rep_fire) begin
            r_rep_cnt <= '0;
            r_rep_arm <= 1'b1;
        end else begin
            r_rep_cnt <= r_rep_cnt + REP_ONE;
        end
    end
`else
    assign w_rep_fire = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE_LO;
            r_cnt     <= '0;
            r_calm    <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_calm    <= w_calm_nxt;
            r_press   <= w_press_nxt | w_rep_fire;
            r_release <= w_release_nxt;
        end
    end

    assign o_calm    = r_calm;
    assign o_press   = r_press;
    assign o_release = r_release;

endmodule

// File: rtl/debouncer_multi.sv
// rtl/debouncer_multi.sv - N_CH independent debounce channels with level, press and release outputs.
// Optional auto-repeat of press is enabled by DEBOUNCE_AUTOREPEAT_EN.
module debouncer_multi
    import debounce_pkg::*;
#(
    parameter int N_CH          = DEF_N_CH,
    parameter int LIMIT         = DEF_LIMIT,
    parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] i_noise,
    output logic [N_CH-1:0] o_calm,
    output logic [N_CH-1:0] o_press,
    output logic [N_CH-1:0] o_release
);

    for (genvar i = 0; i < N_CH; i++) begin : g_chan
        debounce_chan #(
            .LIMIT         (LIMIT),
            .SYNC_STAGES   (SYNC_STAGES),
            .REPEAT_DELAY  (REPEAT_DELAY),
            .REPEAT_PERIOD (REPEAT_PERIOD)
        ) u_chan (
            .clk       (clk),
            .rst       (rst),
            .i_noise   (i_noise[i]),
            .o_calm    (o_calm[i]),
            .o_press   (o_press[i]),
            .o_release (o_release[i])
        );
    end

endmodule
